reg_writeback: RTL and testbench

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback_if.sv | 43 ++++
 rtl/reg_writeback.sv | 129 ++++++++++++
 tb/tb_reg_writeback.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_if.sv
// Writeback bus between the ALU/load units, the decoder busy query and the register file.
// master = producers/consumers around the block, slave = reg_writeback itself.
interface reg_writeback_if #(
  parameter int XLEN = 64
);
  logic                   alu_valid;
  logic [5:0]             alu_rd;
  logic signed [XLEN-1:0] alu_data;
  logic                   alu_ready;

  logic                   ld_valid;
  logic [5:0]             ld_rd;
  logic signed [XLEN-1:0] ld_data;
  logic                   ld_ready;

  logic                   flush;
  logic                   wb_hold;

  logic [5:0]             rd;
  logic signed [XLEN-1:0] wrt_data;
  logic                   RegWrite;

  logic [5:0]             rs1;
  logic [5:0]             rs2;
  logic                   busy_rs1;
  logic                   busy_rs2;

  logic [31:0]            wb_retired;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           flush, wb_hold, rs1, rs2,
    input  alu_ready, ld_ready, rd, wrt_data, RegWrite,
           busy_rs1, busy_rs2, wb_retired
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           flush, wb_hold, rs1, rs2,
    output alu_ready, ld_ready, rd, wrt_data, RegWrite,
           busy_rs1, busy_rs2, wb_retired
  );
endinterface

// File: rtl/reg_writeback.sv
// Register writeback queue: merges ALU and load results into a small FIFO and
// issues at most one register-file write per cycle, with pending-write lookup for the decoder.
module reg_writeback #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_writeback_if.slave wb
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LIM2 = CNT_W'(DEPTH - 2);

  localparam logic [1:0] S_EMPTY  = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_FULL   = 2'd2;

  // x0 and the upper 32 addresses never reach the register file
  function automatic logic writable(input logic [5:0] r);
    return (r[4:0] != 5'd0) && !r[5];
  endfunction

  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d, alu_slot;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [1:0]             occ_q, occ_d;
  logic [5:0]             qrd_q   [DEPTH];
  logic signed [XLEN-1:0] qdata_q [DEPTH];

  logic [5:0]             rd_q;
  logic signed [XLEN-1:0] data_q;
  logic                   rw_q;
  logic [31:0]            ret_q;

  logic                   ld_rdy, alu_rdy, ld_enq, alu_enq, pop;
  logic                   busy1, busy2;
  logic [PTR_W-1:0]       idx;

  // Readiness looks only at the pre-edge occupancy, never at this cycle's pop
  always_comb begin
    ld_rdy   = rst_n & ~wb.flush & (occ_q != S_FULL);
    alu_rdy  = rst_n & ~wb.flush &
               (wb.ld_valid ? (count_q <= CNT_LIM2) : (occ_q != S_FULL));
    ld_enq   = wb.ld_valid  & ld_rdy  & writable(wb.ld_rd);
    alu_enq  = wb.alu_valid & alu_rdy & writable(wb.alu_rd);
    pop      = ~wb.flush & ~wb.wb_hold & (occ_q != S_EMPTY);
    alu_slot = tail_q + PTR_W'(ld_enq);

    if (wb.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop);
      tail_d  = tail_q + PTR_W'(ld_enq) + PTR_W'(alu_enq);
      count_d = count_q + CNT_W'(ld_enq) + CNT_W'(alu_enq) - CNT_W'(pop);
    end

    if (count_d == CNT_ZERO)      occ_d = S_EMPTY;
    else if (count_d == CNT_FULL) occ_d = S_FULL;
    else                          occ_d = S_ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      occ_q   <= S_EMPTY;
      rw_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      ret_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      occ_q   <= occ_d;
      rw_q    <= pop;
      if (pop) begin
        rd_q   <= qrd_q[head_q];
        data_q <= qdata_q[head_q];
        ret_q  <= ret_q + 32'd1;
      end
    end
  end

  // Load result takes the tail slot first when both ports enqueue together
  always_ff @(posedge clk) begin
    if (ld_enq) begin
      qrd_q[tail_q]   <= wb.ld_rd;
      qdata_q[tail_q] <= wb.ld_data;
    end
    if (alu_enq) begin
      qrd_q[alu_slot]   <= wb.alu_rd;
      qdata_q[alu_slot] <= wb.alu_data;
    end
  end

  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (qrd_q[idx] == wb.rs1) busy1 = 1'b1;
        if (qrd_q[idx] == wb.rs2) busy2 = 1'b1;
      end
    end
    // A write on the output stage is still in flight until the regfile samples it
    if (rw_q && rd_q == wb.rs1) busy1 = 1'b1;
    if (rw_q && rd_q == wb.rs2) busy2 = 1'b1;
  end

  assign wb.ld_ready   = ld_rdy;
  assign wb.alu_ready  = alu_rdy;
  assign wb.rd         = rd_q;
  assign wb.wrt_data   = data_q;
  assign wb.RegWrite   = rw_q;
  assign wb.wb_retired = ret_q;
  assign wb.busy_rs1   = busy1 & writable(wb.rs1);
  assign wb.busy_rs2   = busy2 & writable(wb.rs2);

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
module tb_reg_writeback;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  reg_writeback_if #(.XLEN(XLEN)) bus();

  reg_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus.slave)
  );

  typedef struct packed {
    logic [5:0]  rd;
    logic [63:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_valid = 1'b0;
  logic        m_rw;
  logic [5:0]  m_rd;
  logic [63:0] m_data;
  logic [31:0] m_ret;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic wr_ok(input logic [5:0] r);
    return (r[4:0] != 5'd0) && (r[5] == 1'b0);
  endfunction

  function automatic logic exp_busy(input logic [5:0] rs);
    if (!wr_ok(rs)) return 1'b0;
    foreach (q[i]) if (q[i].rd == rs) return 1'b1;
    return m_rw && (m_rd == rs);
  endfunction

  // Inputs change at posedge+2, so the negedge sees stable inputs and settled outputs.
  always @(negedge clk) begin
    int  cnt;
    logic e_ldr, e_alur, popped;
    ent_t e;
    cnt    = q.size();
    e_ldr  = rst_n && !bus.flush && (cnt <= DEPTH - 1);
    e_alur = rst_n && !bus.flush && (bus.ld_valid ? (cnt <= DEPTH - 2) : (cnt <= DEPTH - 1));
    if (m_valid) begin
      chk("RegWrite",   bus.RegWrite,   m_rw);
      chk("rd",         bus.rd,         m_rd);
      chk("wrt_data",   bus.wrt_data,   m_data);
      chk("wb_retired", bus.wb_retired, m_ret);
      chk("ld_ready",   bus.ld_ready,   e_ldr);
      chk("alu_ready",  bus.alu_ready,  e_alur);
      chk("busy_rs1",   bus.busy_rs1,   exp_busy(bus.rs1));
      chk("busy_rs2",   bus.busy_rs2,   exp_busy(bus.rs2));
    end
    if (!rst_n) begin
      q.delete();
      m_rw = 1'b0; m_rd = '0; m_data = '0; m_ret = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (bus.flush) begin
        q.delete();
        m_rw = 1'b0;
      end else begin
        popped = (q.size() > 0) && !bus.wb_hold;
        if (popped) begin
          e = q.pop_front();
          m_rd = e.rd; m_data = e.data; m_ret = m_ret + 32'd1;
        end
        m_rw = popped;
        if (bus.ld_valid && e_ldr && wr_ok(bus.ld_rd))
          q.push_back('{rd: bus.ld_rd, data: bus.ld_data});
        if (bus.alu_valid && e_alur && wr_ok(bus.alu_rd))
          q.push_back('{rd: bus.alu_rd, data: bus.alu_data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.ld_valid = 1'b0;
    bus.flush = 1'b0; bus.wb_hold = 1'b0;
  endtask

  function automatic logic [5:0] rand_rd();
    if ($urandom_range(0, 9) == 0) return 6'($urandom_range(0, 63));
    return 6'($urandom_range(1, 12));
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    bus.rs1 = '0; bus.rs2 = '0;
    bus.ld_rd = '0; bus.ld_data = '0;
    bus.alu_valid = 1'b1; bus.alu_rd = 6'd5; bus.alu_data = 64'h2A;
    #1;
    chk("rst_alu_ready", bus.alu_ready, 1'b0);
    chk("rst_ld_ready",  bus.ld_ready,  1'b0);
    tick(); tick();
    chk("rst_RegWrite", bus.RegWrite,   1'b0);
    chk("rst_rd",       bus.rd,         6'd0);
    chk("rst_wrt_data", bus.wrt_data,   64'd0);
    chk("rst_retired",  bus.wb_retired, 32'd0);

    // single write through an empty queue
    rst_n = 1'b1; bus.rs1 = 6'd5;
    tick();
    chk("single_busy_pending", bus.busy_rs1, 1'b1);
    chk("single_no_write_yet", bus.RegWrite, 1'b0);
    bus.alu_valid = 1'b0;
    tick();
    chk("single_RegWrite", bus.RegWrite, 1'b1);
    chk("single_rd",       bus.rd,       6'd5);
    chk("single_data",     bus.wrt_data, 64'h2A);
    chk("single_busy_out", bus.busy_rs1, 1'b1);
    tick();
    chk("single_RegWrite_drop", bus.RegWrite,   1'b0);
    chk("single_busy_clear",    bus.busy_rs1,   1'b0);
    chk("single_retired",       bus.wb_retired, 32'd1);

    // dual accept: load ahead of ALU
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    bus.ld_valid = 1'b1;  bus.ld_rd = 6'd3;  bus.ld_data = 64'h11;
    bus.alu_valid = 1'b1; bus.alu_rd = 6'd3; bus.alu_data = 64'h22;
    tick();
    idle();
    tick();
    chk("dual_first_rw",   bus.RegWrite, 1'b1);
    chk("dual_first_rd",   bus.rd,       6'd3);
    chk("dual_first_data", bus.wrt_data, 64'h11);
    tick();
    chk("dual_second_rw",   bus.RegWrite, 1'b1);
    chk("dual_second_data", bus.wrt_data, 64'h22);
    tick();
    chk("dual_done_rw",  bus.RegWrite,   1'b0);
    chk("dual_retired",  bus.wb_retired, 32'd2);

    // x0 write is acknowledged and dropped
    bus.alu_valid = 1'b1; bus.alu_rd = 6'd0; bus.alu_data = 64'hFF; bus.rs1 = 6'd0;
    #1;
    chk("x0_alu_ready", bus.alu_ready, 1'b1);
    tick();
    bus.alu_valid = 1'b0;
    chk("x0_busy", bus.busy_rs1, 1'b0);
    tick();
    chk("x0_no_write", bus.RegWrite, 1'b0);

    // fill under hold, then drain at full rate
    bus.wb_hold = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 6'(r); bus.alu_data = 64'(r * 256);
      tick();
    end
    bus.alu_rd = 6'd9;
    #1;
    chk("full_alu_ready", bus.alu_ready, 1'b0);
    chk("full_ld_ready",  bus.ld_ready,  1'b0);
    bus.alu_valid = 1'b0; bus.wb_hold = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      tick();
      chk("drain_rw", bus.RegWrite, 1'b1);
      chk("drain_rd", bus.rd, 6'(r));
    end
    tick();
    chk("drain_done", bus.RegWrite, 1'b0);

    // flush while the head write is on the output stage
    bus.wb_hold = 1'b1;
    for (int r = 7; r <= 9; r++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 6'(r); bus.alu_data = 64'(r);
      tick();
    end
    bus.alu_valid = 1'b0; bus.wb_hold = 1'b0;
    tick();
    chk("flush_head_rw", bus.RegWrite, 1'b1);
    chk("flush_head_rd", bus.rd,       6'd7);
    bus.flush = 1'b1; bus.rs1 = 6'd8;
    #1;
    chk("flush_busy_before", bus.busy_rs1, 1'b1);
    tick();
    bus.flush = 1'b0;
    chk("flush_rw_after",   bus.RegWrite, 1'b0);
    chk("flush_busy_after", bus.busy_rs1, 1'b0);
    repeat (2) begin
      tick();
      chk("flush_no_issue", bus.RegWrite, 1'b0);
    end

    // reset with entries queued
    bus.wb_hold = 1'b1;
    for (int r = 10; r <= 12; r++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 6'(r); bus.alu_data = 64'(r);
      tick();
    end
    bus.alu_valid = 1'b0; bus.rs1 = 6'd10; rst_n = 1'b0;
    tick();
    chk("midrst_rw",      bus.RegWrite,   1'b0);
    chk("midrst_retired", bus.wb_retired, 32'd0);
    chk("midrst_busy",    bus.busy_rs1,   1'b0);
    rst_n = 1'b1; bus.wb_hold = 1'b0;
    repeat (4) begin
      tick();
      chk("midrst_no_write", bus.RegWrite, 1'b0);
    end

    // randomized traffic, checked by the negedge model
    for (int n = 0; n < 3000; n++) begin
      bus.alu_valid = ($urandom_range(0, 99) < 60);
      bus.alu_rd    = rand_rd();
      bus.alu_data  = {$urandom, $urandom};
      bus.ld_valid  = ($urandom_range(0, 99) < 50);
      bus.ld_rd     = rand_rd();
      bus.ld_data   = {$urandom, $urandom};
      bus.flush     = ($urandom_range(0, 99) < 4);
      bus.wb_hold   = ($urandom_range(0, 99) < 30);
      bus.rs1       = 6'($urandom_range(0, 13));
      bus.rs2       = 6'($urandom_range(0, 13));
      rst_n         = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    idle();
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
